// File: rtl/mem_write_arbiter_pkg.sv
// Shared constants and types for mem_write_arbiter.
// Holds the MCB command encodings and the arbiter FSM state type.
package mem_write_arbiter_pkg;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0] MCB_INSTR_READ  = 3'b001;

  // Every grant pushes exactly one word, and the MCB encodes a burst length of 1 as 0.
  localparam logic [5:0] MCB_BL_ONE_WORD = 6'd0;

  typedef enum logic [1:0] {
    MWA_IDLE  = 2'd0,
    MWA_DATA  = 2'd1,
    MWA_CMD   = 2'd2,
    MWA_DRAIN = 2'd3
  } mwa_state_e;

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Write-only MCB user port: the command FIFO and the write-data FIFO.
// The master modport is the arbiter side. The slave modport is the s6_lpddr_ram side.
interface mem_write_arbiter_if #(
  parameter int ADDR_BITS = 30
);

  logic                 mem_cmd_en;
  logic [2:0]           mem_cmd_instr;
  logic [5:0]           mem_cmd_bl;
  logic [ADDR_BITS-1:0] mem_cmd_byte_addr;
  logic                 mem_cmd_full;

  logic                 mem_wr_en;
  logic [3:0]           mem_wr_mask;
  logic [31:0]          mem_wr_data;
  logic                 mem_wr_full;
  logic                 mem_wr_empty;
  logic                 mem_wr_underrun;
  logic                 mem_wr_error;

  modport master (
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
    output mem_wr_en, mem_wr_mask, mem_wr_data,
    input  mem_cmd_full, mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error
  );

  modport slave (
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
    input  mem_wr_en, mem_wr_mask, mem_wr_data,
    output mem_cmd_full, mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error
  );

endinterface

// File: rtl/mem_write_arbiter_rr_grant.sv
// Combinational grant picker for mem_write_arbiter.
// The default is round-robin: the search starts at ptr and the first asserted req wins.
// When MEM_WRITE_ARB_FIXED_PRIO_EN is defined, the search always starts at index 0,
// so the lowest asserted index wins and ptr has no effect.
module mem_write_arbiter_rr_grant #(
  parameter int NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [$clog2(NUM_CLIENTS)-1:0] ptr,
  output logic [NUM_CLIENTS-1:0]         grant,
  output logic [$clog2(NUM_CLIENTS)-1:0] index,
  output logic                           any
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  logic [IDX_W-1:0] start;

`ifdef MEM_WRITE_ARB_FIXED_PRIO_EN
  assign start = ptr & {IDX_W{1'b0}};
`else
  assign start = ptr;
`endif

  // Walk the clients in rotated order from start and keep the first requester found.
  always_comb begin
    int cand;
    // NOTE: every output is given a default before the loop, so no path leaves a value held and no latch is inferred.
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = (int'(start) + i) % NUM_CLIENTS;
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = cand[IDX_W-1:0];
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: one write-only MCB user port shared by NUM_CLIENTS single-word writers.
// Each grant runs this sequence: push data word, push write command, wait for the write FIFO
// to drain, then pulse cli_done to the client.
// Define MEM_WRITE_ARB_FIXED_PRIO_EN to use fixed lowest-index priority instead of round-robin.
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_BITS   = 30
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             calib_done,
  input  logic [NUM_CLIENTS-1:0]           cli_req,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cli_addr,
  input  logic [NUM_CLIENTS*32-1:0]        cli_data,
  input  logic [NUM_CLIENTS*4-1:0]         cli_mask,
  output logic [NUM_CLIENTS-1:0]           cli_done,
  mem_write_arbiter_if.master              mem,
  output logic                             arb_error
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  mwa_state_e             state_q, state_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_CLIENTS-1:0] gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic [3:0]             mask_q, mask_d;
  logic                   wr_en_q, wr_en_d;
  logic                   cmd_en_q, cmd_en_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  logic                   arb_error_q, arb_error_d;

  logic [NUM_CLIENTS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  mem_write_arbiter_rr_grant #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_grant (
    .req   (cli_req),
    .ptr   (rr_ptr_q),
    .grant (pick_onehot),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Next-state and next-output logic for the grant sequence IDLE -> DATA -> CMD -> DRAIN.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    wr_en_d     = 1'b0;
    cmd_en_d    = 1'b0;
    done_d      = '0;
    arb_error_d = arb_error_q | mem.mem_wr_underrun | mem.mem_wr_error;

    unique case (state_q)
      MWA_IDLE: begin
        // Latch the payload at grant time, so later changes on cli_* cannot reach the transfer in flight.
        if (calib_done && pick_any) begin
          gnt_idx_d = pick_idx;
          gnt_oh_d  = pick_onehot;
          addr_d    = cli_addr[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
          data_d    = cli_data[int'(pick_idx)*32 +: 32];
          mask_d    = cli_mask[int'(pick_idx)*4 +: 4];
          state_d   = MWA_DATA;
        end
      end
      MWA_DATA: begin
        if (!mem.mem_wr_full) begin
          wr_en_d = 1'b1;
          state_d = MWA_CMD;
        end
      end
      MWA_CMD: begin
        if (!mem.mem_cmd_full) begin
          cmd_en_d = 1'b1;
          state_d  = MWA_DRAIN;
        end
      end
      MWA_DRAIN: begin
        if (mem.mem_wr_empty) begin
          done_d   = gnt_oh_q;
          rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
          state_d  = MWA_IDLE;
        end
      end
      default: state_d = MWA_IDLE;
    endcase
  end

  // State and registered outputs. Reset abandons any transfer in flight without pulsing done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MWA_IDLE;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= '0;
      // NOTE: the latched payload is cleared on reset as well as the control state, so the mem_* buses read 0 rather than stale data.
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      wr_en_q     <= 1'b0;
      cmd_en_q    <= 1'b0;
      done_q      <= '0;
      arb_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the pre-edge value of every _d.
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      wr_en_q     <= wr_en_d;
      cmd_en_q    <= cmd_en_d;
      done_q      <= done_d;
      arb_error_q <= arb_error_d;
    end
  end

  assign mem.mem_wr_en         = wr_en_q;
  assign mem.mem_wr_data       = data_q;
  assign mem.mem_wr_mask       = mask_q;
  assign mem.mem_cmd_en        = cmd_en_q;
  assign mem.mem_cmd_instr     = MCB_INSTR_WRITE;
  assign mem.mem_cmd_bl        = MCB_BL_ONE_WORD;
  assign mem.mem_cmd_byte_addr = addr_q & ~ADDR_BITS'(3);
  assign cli_done              = done_q;
  assign arb_error             = arb_error_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter. Stimulus pushes the expected write words,
// commands and done pulses into queues. A negedge monitor pops and compares them
// whenever the DUT fires wr_en, cmd_en or cli_done.
module tb_mem_write_arbiter;

  localparam int N  = 4;
  localparam int AB = 30;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_exp_t;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          calib_done = 1'b0;
  logic [N-1:0]  cli_req;
  logic [N*AB-1:0] cli_addr = '0;
  logic [N*32-1:0] cli_data = '0;
  logic [N*4-1:0]  cli_mask = '0;
  logic [N-1:0]  cli_done;
  logic          arb_error;

  mem_write_arbiter_if #(.ADDR_BITS(AB)) bus ();

  mem_write_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_BITS   (AB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .calib_done (calib_done),
    .cli_req    (cli_req),
    .cli_addr   (cli_addr),
    .cli_data   (cli_data),
    .cli_mask   (cli_mask),
    .cli_done   (cli_done),
    .mem        (bus),
    .arb_error  (arb_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_exp_t        exp_wr[$];
  logic [AB-1:0]  exp_cmd[$];
  int             exp_done[$];

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt = 0, cmd_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  int issued[N] = '{default: 0};
  int served[N] = '{default: 0};

  // A client requests while it has more writes issued than completed, and drops its request in the cli_done cycle.
  always_comb begin
    cli_req = '0;
    for (int i = 0; i < N; i++) cli_req[i] = (issued[i] > served[i]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: compares every DUT output event against the head of its queue.
  wr_exp_t       mon_wr;
  logic [AB-1:0] mon_addr;
  int            mon_idx;
  always @(negedge clk) begin
    if (bus.mem_wr_en && bus.mem_cmd_en) fail_event("wr_cmd_overlap", "got both enables high, expected at most one");
    if (bus.mem_wr_en) begin
      wr_cnt++;
      if (exp_wr.size() == 0) fail_event("wr_unexpected", "got wr_en, expected none");
      else begin
        mon_wr = exp_wr.pop_front();
        check("wr_data", bus.mem_wr_data, mon_wr.data);
        check("wr_mask", bus.mem_wr_mask, mon_wr.mask);
      end
    end
    if (bus.mem_cmd_en) begin
      cmd_cnt++;
      if (exp_cmd.size() == 0) fail_event("cmd_unexpected", "got cmd_en, expected none");
      else begin
        mon_addr = exp_cmd.pop_front();
        check("cmd_addr", bus.mem_cmd_byte_addr, mon_addr);
        check("cmd_instr", bus.mem_cmd_instr, 3'b000);
        check("cmd_bl", bus.mem_cmd_bl, 6'd0);
      end
    end
    if (cli_done != '0) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("done_onehot", $countones(cli_done), 1);
      mon_idx = 0;
      for (int i = N - 1; i >= 0; i--) if (cli_done[i]) mon_idx = i;
      served[mon_idx]++;
      if (exp_done.size() == 0) fail_event("done_unexpected", "got cli_done, expected none");
      else check("done_client", mon_idx, exp_done.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_payload(input int i, input logic [AB-1:0] a, input logic [31:0] d, input logic [3:0] m);
    cli_addr[i*AB +: AB] = a;
    cli_data[i*32 +: 32] = d;
    cli_mask[i*4 +: 4]   = m;
  endtask

  task automatic expect_txn(input int i, input logic [AB-1:0] aligned, input logic [31:0] d, input logic [3:0] m);
    wr_exp_t e;
    e.data = d;
    e.mask = m;
    exp_wr.push_back(e);
    exp_cmd.push_back(aligned);
    exp_done.push_back(i);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (done_cnt < target) fail_event(name, "got no cli_done within budget, expected one");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, bus.mem_wr_en, 0);
    check({tag, "_cmd_en"}, bus.mem_cmd_en, 0);
    check({tag, "_cli_done"}, cli_done, 0);
    check({tag, "_arb_error"}, arb_error, 0);
    check({tag, "_cmd_addr"}, bus.mem_cmd_byte_addr, 0);
    check({tag, "_wr_data"}, bus.mem_wr_data, 0);
    check({tag, "_wr_mask"}, bus.mem_wr_mask, 0);
  endtask

  // Hand-computed table for the all-clients test.
  logic [AB-1:0] t2_addr[N]    = '{30'h100, 30'h201, 30'h302, 30'h403};
  logic [AB-1:0] t2_aligned[N] = '{30'h100, 30'h200, 30'h300, 30'h400};
  logic [31:0]   t2_data[N]    = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
  logic [3:0]    t2_mask[N]    = '{4'h1, 4'h2, 4'h4, 4'h8};
`ifdef MEM_WRITE_ARB_FIXED_PRIO_EN
  int t2_order[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
  // The previous grant went to client 0, so the pointer starts at 1.
  int t2_order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif

  int req_cyc, base_wr, base_cmd, base_done;

  initial begin
    bus.mem_cmd_full    = 1'b0;
    bus.mem_wr_full     = 1'b0;
    bus.mem_wr_empty    = 1'b1;
    bus.mem_wr_underrun = 1'b0;
    bus.mem_wr_error    = 1'b0;

    // Reset state
    repeat (3) step();
    check_idle_outputs("rst");
    reset      = 1'b0;
    calib_done = 1'b1;
    step();

    // T1: single request from client 1, with its payload changed after the grant
    set_payload(1, 30'h1235, 32'hDEAD_BEEF, 4'h0);
    expect_txn(1, 30'h1234, 32'hDEAD_BEEF, 4'h0);
    issued[1]++;
    req_cyc = cyc;
    step();
    step();
    set_payload(1, 30'h3FFF_FFFC, 32'h1234_5678, 4'hF);
    wait_dones(1, 40, "t1_done_timeout");
    check("t1_latency", last_done_cyc - req_cyc, 4);

    // T3: wr_full stalls DATA for 10 cycles, then cmd_full stalls CMD for 5 cycles
    step();
    set_payload(2, 30'h0ABC_DEF7, 32'hCAFE_F00D, 4'b0101);
    expect_txn(2, 30'h0ABC_DEF4, 32'hCAFE_F00D, 4'b0101);
    bus.mem_wr_full  = 1'b1;
    bus.mem_cmd_full = 1'b1;
    issued[2]++;
    req_cyc  = cyc;
    base_wr  = wr_cnt;
    base_cmd = cmd_cnt;
    repeat (11) step();
    check("t3_no_wr_while_full", wr_cnt, base_wr);
    bus.mem_wr_full = 1'b0;
    repeat (6) step();
    check("t3_no_cmd_while_full", cmd_cnt, base_cmd);
    bus.mem_cmd_full = 1'b0;
    wait_dones(2, 40, "t3_done_timeout");
    check("t3_latency", last_done_cyc - req_cyc, 19);

    // T4: calib_done gating, and calib_done dropping mid-transaction
    step();
    calib_done = 1'b0;
    set_payload(3, 30'h2000_0002, 32'h0F0F_0F0F, 4'b1000);
    expect_txn(3, 30'h2000_0000, 32'h0F0F_0F0F, 4'b1000);
    issued[3]++;
    base_wr   = wr_cnt;
    base_cmd  = cmd_cnt;
    base_done = done_cnt;
    repeat (8) step();
    check("t4_no_wr_uncalib", wr_cnt, base_wr);
    check("t4_no_cmd_uncalib", cmd_cnt, base_cmd);
    check("t4_no_done_uncalib", done_cnt, base_done);
    calib_done = 1'b1;
    req_cyc    = cyc;
    step();
    calib_done = 1'b0;
    set_payload(0, 30'h0000_0FFF, 32'h1111_2222, 4'b0011);
    expect_txn(0, 30'h0000_0FFC, 32'h1111_2222, 4'b0011);
    issued[0]++;
    wait_dones(3, 40, "t4_done_timeout");
    check("t4_latency", last_done_cyc - req_cyc, 4);
    repeat (6) step();
    check("t4_no_new_grant_wr", wr_cnt, base_wr + 1);
    check("t4_no_new_grant_done", done_cnt, 3);
    calib_done = 1'b1;
    req_cyc    = cyc;
    wait_dones(4, 40, "t4b_done_timeout");
    check("t4b_latency", last_done_cyc - req_cyc, 4);

    // T2: all four clients request, two writes each
    step();
    for (int i = 0; i < N; i++) begin
      set_payload(i, t2_addr[i], t2_data[i], t2_mask[i]);
      issued[i] += 2;
    end
    for (int k = 0; k < 8; k++)
      expect_txn(t2_order[k], t2_aligned[t2_order[k]], t2_data[t2_order[k]], t2_mask[t2_order[k]]);
    wait_dones(12, 120, "t2_done_timeout");

    // T7: DRAIN waits until the write FIFO reports empty
    step();
    set_payload(0, 30'h0000_0046, 32'h0000_0044, 4'h0);
    expect_txn(0, 30'h0000_0044, 32'h0000_0044, 4'h0);
    bus.mem_wr_empty = 1'b0;
    issued[0]++;
    req_cyc   = cyc;
    base_done = done_cnt;
    repeat (6) step();
    check("t7_no_done_while_nonempty", done_cnt, base_done);
    bus.mem_wr_empty = 1'b1;
    wait_dones(13, 40, "t7_done_timeout");
    check("t7_latency", last_done_cyc - req_cyc, 7);

    // T6: an underrun pulse makes arb_error sticky, and arbitration carries on
    step();
    bus.mem_wr_underrun = 1'b1;
    step();
    bus.mem_wr_underrun = 1'b0;
    check("t6_arb_error_set", arb_error, 1);
    set_payload(1, 30'h0000_0800, 32'h7777_8888, 4'h0);
    expect_txn(1, 30'h0000_0800, 32'h7777_8888, 4'h0);
    issued[1]++;
    wait_dones(14, 40, "t6_done_timeout");
    step();
    check("t6_arb_error_sticky", arb_error, 1);

    // T5: reset during DRAIN abandons the transfer, which is then granted again after release
    step();
    set_payload(2, 30'h0000_1111, 32'h5555_AAAA, 4'b0110);
    expect_txn(2, 30'h0000_1110, 32'h5555_AAAA, 4'b0110);
    exp_wr.push_back(exp_wr[exp_wr.size()-1]);
    exp_cmd.push_back(30'h0000_1110);
    issued[2]++;
    base_done = done_cnt;
    repeat (3) step();
    reset = 1'b1;
    step();
    check_idle_outputs("t5_rst");
    check("t5_no_done_in_reset", done_cnt, base_done);
    reset   = 1'b0;
    req_cyc = cyc;
    wait_dones(base_done + 1, 40, "t5_done_timeout");
    check("t5_regrant_latency", last_done_cyc - req_cyc, 4);

    // mem_wr_error also sets arb_error
    step();
    bus.mem_wr_error = 1'b1;
    step();
    bus.mem_wr_error = 1'b0;
    check("t6b_arb_error_on_error", arb_error, 1);

    repeat (4) step();
    check("left_wr", exp_wr.size(), 0);
    check("left_cmd", exp_cmd.size(), 0);
    check("left_done", exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
